free_list_mw: RTL

- Next-generation physical register free list for the OoO rename stage.
- Supports DISPATCH_WIDTH allocations and COMMIT_WIDTH frees per cycle.
- Holds NUM_CKPT internal branch checkpoints for single-cycle mispredict recovery, and reports a free-register count plus a ready signal to dispatch.
- Busy-vector encoding: 1 = allocated, 0 = free. Physical register 0 is permanently allocated.

---
 rtl/free_list_mw.sv | 106 ++++++++++
 1 files changed

// File: rtl/free_list_mw.sv
// free_list_mw
// Physical register free list for the rename stage. Tracks a busy vector
// (1 = allocated, 0 = free; preg 0 is permanently allocated). It offers the
// DISPATCH_WIDTH lowest free pregs each cycle and accepts COMMIT_WIDTH frees
// per cycle. NUM_CKPT checkpoint slots give single-cycle mispredict recovery.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   alloc_req         per-lane allocation request
//   alloc_paddr       lane k = k-th lowest free preg (0 if none)
//   alloc_ready       at least DISPATCH_WIDTH pregs are free
//   free_valid        per-lane release strobe
//   free_paddr        per-lane preg to release
//   ckpt_save         capture next busy vector into slot ckpt_save_id
//   ckpt_restore      reload busy vector from slot ckpt_restore_id
//   free_count        registered count of free pregs
//   busy_vec          current busy vector
module free_list_mw #(
  parameter  int NUM_PREGS      = 64,
  parameter  int DISPATCH_WIDTH = 2,
  parameter  int COMMIT_WIDTH   = 2,
  parameter  int NUM_CKPT       = 4,
  localparam int PW             = $clog2(NUM_PREGS),
  localparam int CW             = $clog2(NUM_CKPT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DISPATCH_WIDTH-1:0]    alloc_req,
  output logic [DISPATCH_WIDTH*PW-1:0] alloc_paddr,
  output logic                         alloc_ready,
  input  logic [COMMIT_WIDTH-1:0]      free_valid,
  input  logic [COMMIT_WIDTH*PW-1:0]   free_paddr,
  input  logic                         ckpt_save,
  input  logic [CW-1:0]                ckpt_save_id,
  input  logic                         ckpt_restore,
  input  logic [CW-1:0]                ckpt_restore_id,
  output logic [PW:0]                  free_count,
  output logic [NUM_PREGS-1:0]         busy_vec
);

  localparam logic [NUM_PREGS-1:0] RESET_VEC = NUM_PREGS'(1);

  logic [NUM_PREGS-1:0] ckpt_q [NUM_CKPT];
  logic [NUM_PREGS-1:0] grant_mask;
  logic [NUM_PREGS-1:0] free_mask;
  logic [NUM_PREGS-1:0] busy_nxt;
  logic [PW:0]          count_nxt;
  logic [PW:0]          found;

  // Lane k takes the k-th free preg regardless of which lanes request, so a
  // lane that stays idle never shifts the pregs offered to higher lanes.
  always_comb begin
    alloc_paddr = '0;
    found       = '0;
    for (int i = 1; i < NUM_PREGS; i++) begin
      if (!busy_vec[i]) begin
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
          if (found == (PW+1)'(k)) alloc_paddr[k*PW +: PW] = PW'(i);
        end
        found = found + (PW+1)'(1);
      end
    end
  end

  assign alloc_ready = (free_count >= (PW+1)'(DISPATCH_WIDTH));

  always_comb begin
    grant_mask = '0;
    free_mask  = '0;
    // All-or-nothing grant: alloc_ready guarantees every lane has a real preg.
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      if (alloc_req[k] && alloc_ready) grant_mask[alloc_paddr[k*PW +: PW]] = 1'b1;
    end
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      if (free_valid[j] && (free_paddr[j*PW +: PW] != '0))
        free_mask[free_paddr[j*PW +: PW]] = 1'b1;
    end
    // A restore drops this cycle's grants but still honours this cycle's frees.
    if (ckpt_restore) busy_nxt = ckpt_q[ckpt_restore_id] & ~free_mask;
    else              busy_nxt = (busy_vec | grant_mask) & ~free_mask;
    busy_nxt[0] = 1'b1;
    count_nxt = '0;
    for (int i = 1; i < NUM_PREGS; i++) begin
      if (!busy_nxt[i]) count_nxt = count_nxt + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_vec   <= RESET_VEC;
      free_count <= (PW+1)'(NUM_PREGS - 1);
      for (int c = 0; c < NUM_CKPT; c++) ckpt_q[c] <= RESET_VEC;
    end else begin
      busy_vec   <= busy_nxt;
      free_count <= count_nxt;
      // Frees scrub every slot so released pregs stay free across a restore.
      for (int c = 0; c < NUM_CKPT; c++) begin
        if (ckpt_save && !ckpt_restore && (ckpt_save_id == CW'(c)))
          ckpt_q[c] <= busy_nxt;
        else
          ckpt_q[c] <= ckpt_q[c] & ~free_mask;
      end
    end
  end

endmodule
